// File: rtl/i_mem_responder.sv
// i_mem_responder: main-memory side of the instruction refill interface.
// Returns a 4-word line on IDBUS a fixed number of cycles after IREQ is accepted,
// with a word-wide load port for preloading program images.
// Optional build macro PREFETCH_BUF_EN adds a one-line next-line prefetch buffer.
module i_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IREQ,
    input  logic [31:0]  IADDR,
    output logic [127:0] IDBUS,
    output logic         IRDY,
    output logic         IERR,
    input  logic         LD_WE,
    input  logic [31:0]  LD_ADDR,
    input  logic [31:0]  LD_DATA
);
    localparam int unsigned WORD_W   = $clog2(MEM_WORDS);
    localparam int unsigned LINES    = MEM_WORDS / 4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD, S_PF} state_t;

    logic [31:0]  mem_q [MEM_WORDS];

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [27:0]  line_q, line_d;
    logic [127:0] idbus_q, idbus_d;
    logic         irdy_q, irdy_d;
    logic         ierr_q, ierr_d;

    logic [27:0]       req_line_c;
    logic [31:0]       ld_off_c;
    logic              ld_ok_c;
    logic [WORD_W-1:0] ld_idx_c;

    assign req_line_c = 28'((IADDR - ADDR_BASE) >> 4);
    assign ld_off_c   = LD_ADDR - ADDR_BASE;
    assign ld_ok_c    = LD_WE && ((ld_off_c >> 2) < 32'(MEM_WORDS));
    assign ld_idx_c   = WORD_W'(ld_off_c >> 2);

    assign IDBUS = idbus_q;
    assign IRDY  = irdy_q;
    assign IERR  = ierr_q;

    function automatic logic line_in_range(input logic [27:0] l);
        return 32'(l) < 32'(LINES);
    endfunction

    function automatic logic [127:0] read_line(input logic [27:0] l);
        logic [WORD_W-1:0] base;
        base = WORD_W'({l, 2'b00});
        return {mem_q[base], mem_q[base + WORD_W'(1)],
                mem_q[base + WORD_W'(2)], mem_q[base + WORD_W'(3)]};
    endfunction

    function automatic logic [127:0] fetch_line(input logic [27:0] l);
        return line_in_range(l) ? read_line(l) : '1;
    endfunction

`ifdef PREFETCH_BUF_EN
    logic         pf_valid_q, pf_valid_d;
    logic [27:0]  pf_tag_q, pf_tag_d;
    logic [127:0] pf_buf_q, pf_buf_d;
    logic         pf_pend_q, pf_pend_d;
    logic         hit_q, hit_d;
    logic         pf_wr_hit_c;

    assign pf_wr_hit_c = ld_ok_c && (28'(ld_off_c >> 4) == pf_tag_q);
`endif

    // Storage write port; reads elsewhere see the pre-edge contents
    always_ff @(posedge clk) begin
        if (ld_ok_c) begin
            mem_q[ld_idx_c] <= LD_DATA;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            idbus_q    <= '0;
            irdy_q     <= 1'b0;
            ierr_q     <= 1'b0;
`ifdef PREFETCH_BUF_EN
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_buf_q   <= '0;
            pf_pend_q  <= 1'b0;
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            idbus_q    <= idbus_d;
            irdy_q     <= irdy_d;
            ierr_q     <= ierr_d;
`ifdef PREFETCH_BUF_EN
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_buf_q   <= pf_buf_d;
            pf_pend_q  <= pf_pend_d;
            hit_q      <= hit_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        idbus_d = idbus_q;
        irdy_d  = 1'b0;
        ierr_d  = 1'b0;
`ifdef PREFETCH_BUF_EN
        pf_valid_d = pf_valid_q && !pf_wr_hit_c;
        pf_tag_d   = pf_tag_q;
        pf_buf_d   = pf_buf_q;
        pf_pend_d  = pf_pend_q;
        hit_d      = hit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (IREQ) begin
                    state_d = S_WAIT;
                    line_d  = req_line_c;
                    cnt_d   = CNT_INIT;
`ifdef PREFETCH_BUF_EN
                    // A buffer hit waits a single cycle instead of the full latency
                    hit_d = pf_valid_q && !pf_wr_hit_c && (req_line_c == pf_tag_q);
                    if (hit_d) begin
                        cnt_d = 4'd0;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    irdy_d  = 1'b1;
                    ierr_d  = !line_in_range(line_q);
                    idbus_d = fetch_line(line_q);
`ifdef PREFETCH_BUF_EN
                    if (hit_q) begin
                        idbus_d = pf_buf_q;
                        ierr_d  = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_IDLE;
`ifdef PREFETCH_BUF_EN
                if (line_in_range(line_q) && line_in_range(line_q + 28'd1)) begin
                    state_d    = S_PF;
                    cnt_d      = CNT_INIT;
                    pf_tag_d   = line_q + 28'd1;
                    pf_valid_d = 1'b0;
                    pf_pend_d  = 1'b0;
                end
`endif
            end
`ifdef PREFETCH_BUF_EN
            S_PF: begin
                if (IREQ && !pf_pend_q && (req_line_c != pf_tag_q)) begin
                    // Request for another line abandons the fill
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    line_d  = req_line_c;
                    hit_d   = 1'b0;
                end else begin
                    pf_pend_d = pf_pend_q || IREQ;
                    if (cnt_q == 4'd0) begin
                        pf_buf_d   = read_line(pf_tag_q);
                        pf_valid_d = !pf_wr_hit_c;
                        pf_pend_d  = 1'b0;
                        state_d    = S_IDLE;
                        if (pf_pend_q || IREQ) begin
                            state_d = S_RESP;
                            line_d  = pf_tag_q;
                            idbus_d = read_line(pf_tag_q);
                            irdy_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_i_mem_responder.sv
// Self-checking bench for i_mem_responder: directed steps plus randomized
// requests checked against an array model of the memory contents.
module tb_i_mem_responder;
    localparam int          MW   = 4096;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          WI_W = $clog2(MW);

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         IREQ  = 1'b0;
    logic [31:0]  IADDR = '0;
    logic [127:0] IDBUS;
    logic         IRDY;
    logic         IERR;
    logic         LD_WE   = 1'b0;
    logic [31:0]  LD_ADDR = '0;
    logic [31:0]  LD_DATA = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [MW];

    i_mem_responder #(
        .MEM_WORDS (MW),
        .LATENCY   (LAT),
        .ADDR_BASE (BASE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IREQ    (IREQ),
        .IADDR   (IADDR),
        .IDBUS   (IDBUS),
        .IRDY    (IRDY),
        .IERR    (IERR),
        .LD_WE   (LD_WE),
        .LD_ADDR (LD_ADDR),
        .LD_DATA (LD_DATA)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: a word is stored only when its byte offset lies inside the memory
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] w;
        w = (addr - BASE) >> 2;
        if (w < 32'(MW)) ref_mem[WI_W'(w)] = data;
    endtask

    function automatic logic exp_err(input logic [31:0] addr);
        return ((addr - BASE) >> 4) >= 32'(MW / 4);
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] addr);
        logic [31:0]     line;
        logic [WI_W-1:0] w;
        line = (addr - BASE) >> 4;
        if (line >= 32'(MW / 4)) return '1;
        w = WI_W'(line * 4);
        return {ref_mem[w], ref_mem[w + WI_W'(1)], ref_mem[w + WI_W'(2)], ref_mem[w + WI_W'(3)]};
    endfunction

    task automatic ld_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        LD_WE = 1'b1; LD_ADDR = addr; LD_DATA = data;
        @(negedge clk);
        LD_WE = 1'b0;
        model_write(addr, data);
    endtask

    // One request; optional load write aimed at the RESP-entry edge
    task automatic do_req(input string tag, input logic [31:0] addr, input int exp_lat,
                          input bit wr_en, input logic [31:0] wr_addr, input logic [31:0] wr_data);
        logic [127:0] exp_d;
        logic         exp_e;
        int           lat;
        @(negedge clk);
        IREQ = 1'b1; IADDR = addr;
        @(posedge clk); #1;
        IREQ = 1'b0; IADDR = $urandom();
        exp_d = exp_line(addr);
        exp_e = exp_err(addr);
        lat = 0;
        while (IRDY !== 1'b1 && lat < LAT + 8) begin
            if (wr_en && lat == exp_lat - 1) begin
                LD_WE = 1'b1; LD_ADDR = wr_addr; LD_DATA = wr_data;
            end
            @(posedge clk); #1;
            lat++;
            if (LD_WE) begin
                LD_WE = 1'b0;
                model_write(wr_addr, wr_data);
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_idbus"}, IDBUS, exp_d);
        check({tag, "_ierr"}, 128'(IERR), 128'(exp_e));
        @(posedge clk); #1;
        check({tag, "_hold_irdy"}, 128'({IRDY, IERR}), 128'(0));
        @(posedge clk); #1;
        check({tag, "_idbus_held"}, IDBUS, exp_d);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] wa;
        int          r;
        int          line;
        logic        exp_rdy;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_idbus", IDBUS, 128'(0));
        check("reset_irdy_ierr", 128'({IRDY, IERR}), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Preload: words 0..7 fixed pattern, rest of lines 0..7 and top 4 lines random
        for (int i = 0; i < 8; i++) ld_write(BASE + 32'(i * 4), 32'h1000_0000 + 32'(i));
        for (int i = 8; i < 32; i++) ld_write(BASE + 32'(i * 4), $urandom());
        for (int i = MW - 16; i < MW; i++) ld_write(BASE + 32'(i * 4), $urandom());

        // Basic line return
        do_req("t1", BASE + 32'h10, LAT, 1'b0, '0, '0);
        check("t1_const", IDBUS, 128'h10000004_10000005_10000006_10000007);

        // IREQ held high: one pulse per accepted request, re-accept after HOLD
        @(negedge clk);
        IREQ = 1'b1; IADDR = BASE + 32'h10;
        for (int k = 0; k <= 2 * LAT + 5; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k >= LAT) && (((k - LAT) % (LAT + 3)) == 0);
            check("t2_irdy", 128'(IRDY), 128'(exp_rdy));
        end
        IREQ = 1'b0;

        // Read-before-write on the RESP-entry edge
        do_req("t5_old", BASE + 32'h10, LAT, 1'b1, BASE + 32'h14, 32'hCAFE_0005);
        check("t5_old_const", IDBUS, 128'h10000004_10000005_10000006_10000007);
        do_req("t5_new", BASE + 32'h10, LAT, 1'b0, '0, '0);
        check("t5_new_const", IDBUS, 128'h10000004_CAFE0005_10000006_10000007);

        // Range boundaries
        do_req("t3_oor", BASE + 32'h4000, LAT, 1'b0, '0, '0);
        do_req("t3_last", BASE + 32'h3FF0, LAT, 1'b0, '0, '0);
        do_req("t3_far", BASE + 32'hFFFF_FFF0, LAT, 1'b0, '0, '0);

        // Reset while waiting: no response, outputs cleared, storage kept
        @(negedge clk);
        IREQ = 1'b1; IADDR = BASE + 32'h20;
        @(posedge clk); #1;
        IREQ = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t4_idbus", IDBUS, 128'(0));
        check("t4_irdy_ierr", 128'({IRDY, IERR}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk); #1;
            check("t4_no_resp", 128'(IRDY), 128'(0));
        end
        do_req("t4_after", BASE + 32'h0, LAT, 1'b0, '0, '0);

`ifndef PREFETCH_BUF_EN
        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            for (int j = 0; j < r; j++) begin
                if ($urandom_range(0, 3) == 0)
                    wa = BASE + 32'h4000 + 32'($urandom_range(0, 31) * 4);
                else if ($urandom_range(0, 1) == 0)
                    wa = BASE + 32'($urandom_range(0, 31) * 4);
                else
                    wa = BASE + 32'($urandom_range(MW - 16, MW - 1) * 4);
                ld_write(wa, $urandom());
            end
            r = $urandom_range(0, 9);
            if (r < 5)      line = $urandom_range(0, 7);
            else if (r < 8) line = $urandom_range(MW / 4 - 4, MW / 4 - 1);
            else            line = $urandom_range(MW / 4, 32'h00FF_FFFF);
            addr = BASE + 32'(line * 16) + 32'($urandom_range(0, 15));
            wa = BASE + 32'($urandom_range(0, 31) * 4);
            do_req("rand", addr, LAT, 1'($urandom_range(0, 1)), wa, $urandom());
        end
`else
        // Next-line prefetch: hit after fill, then miss after invalidating write
        do_req("t6_fill", BASE + 32'h00, LAT, 1'b0, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        do_req("t6_hit", BASE + 32'h10, 1, 1'b0, '0, '0);
        do_req("t6_fill2", BASE + 32'h00, LAT, 1'b0, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        ld_write(BASE + 32'h14, 32'h5555_AAAA);
        do_req("t6_inval", BASE + 32'h10, LAT, 1'b0, '0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
